// File: rtl/pll_dda_stepper.sv
// PLL dynamic-delay stepper.
// Walks the PLL delay one unit at a time from CUR_STEP toward a requested
// target. Each unit step is applied, held for SETTLE_CYC cycles, and then
// lock is awaited (bounded by LOCK_TIMEOUT) before the next step.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | waiting for REQ; range-checks TARGET
// ST_APPLY    | move CUR_STEP one unit toward target, drive DDA outputs
// ST_SETTLE   | hold DDA outputs SETTLE_CYC cycles, lock ignored
// ST_WAIT_LOCK| wait for synchronized lock, bounded by LOCK_TIMEOUT cycles
// ST_FINISH   | target reached; pulse DONE on the way back to idle
module pll_dda_stepper #(
  parameter int SETTLE_CYC   = 16,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic       CLKINB_DEL,
  input  logic       RSTB,
  input  logic       REQ,
  input  logic [4:0] TARGET,
  input  logic       LOCK,
  output logic       DDAMODE,
  output logic       DDAIZR,
  output logic       DDAILAG,
  output logic [2:0] DDAIDEL,
  output logic [4:0] CUR_STEP,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_WAIT_LOCK,
    ST_FINISH
  } state_t;

  localparam logic [7:0]  SETTLE_LD = 8'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_LAST  = 16'(LOCK_TIMEOUT - 1);

  state_t      state_q, state_nx;
  logic [4:0]  tgt_q, tgt_nx;
  logic [4:0]  step_nx;
  logic [4:0]  step_inc;
  logic [7:0]  settle_q, settle_nx;
  logic [15:0] tmo_q, tmo_nx;
  logic        mode_nx, izr_nx, lag_nx;
  logic [2:0]  del_nx;
  logic        busy_nx, done_nx, err_nx;
  logic        lock_meta, lock_s;
  logic        tgt_legal;

  // LOCK crosses from the PLL domain; only lock_s is used past this point
  always_ff @(posedge CLKINB_DEL or posedge RSTB) begin
    if (RSTB) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= LOCK;
      lock_s    <= lock_meta;
    end
  end

  // Range check of the incoming target and the next unit step toward it
  always_comb begin
    tgt_legal = ($signed(TARGET) >= -5'sd8) && ($signed(TARGET) <= 5'sd8);
    step_inc  = ($signed(tgt_q) > $signed(CUR_STEP)) ? CUR_STEP + 5'd1
                                                     : CUR_STEP - 5'd1;
  end

  // Next-state and next-output decode; DDA outputs only change in APPLY
  always_comb begin
    state_nx  = state_q;
    tgt_nx    = tgt_q;
    step_nx   = CUR_STEP;
    settle_nx = settle_q;
    tmo_nx    = tmo_q;
    mode_nx   = DDAMODE;
    izr_nx    = DDAIZR;
    lag_nx    = DDAILAG;
    del_nx    = DDAIDEL;
    busy_nx   = BUSY;
    done_nx   = 1'b0;
    err_nx    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (REQ) begin
          if (tgt_legal) begin
            tgt_nx   = TARGET;
            busy_nx  = 1'b1;
            state_nx = (TARGET == CUR_STEP) ? ST_FINISH : ST_APPLY;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      ST_APPLY: begin
        step_nx   = step_inc;
        mode_nx   = 1'b1;
        izr_nx    = (step_inc == 5'd0);
        lag_nx    = step_inc[4];
        // magnitude-1 code: s-1 for positive, |s|-1 == ~s for negative
        if (step_inc == 5'd0)
          del_nx = 3'd0;
        else if (step_inc[4])
          del_nx = ~step_inc[2:0];
        else
          del_nx = step_inc[2:0] - 3'd1;
        settle_nx = SETTLE_LD;
        state_nx  = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == 8'd0) begin
          tmo_nx   = 16'd0;
          state_nx = ST_WAIT_LOCK;
        end else begin
          settle_nx = settle_q - 8'd1;
        end
      end
      ST_WAIT_LOCK: begin
        if (lock_s) begin
          state_nx = (CUR_STEP == tgt_q) ? ST_FINISH : ST_APPLY;
        end else if (tmo_q == TMO_LAST) begin
          err_nx   = 1'b1;
          busy_nx  = 1'b0;
          state_nx = ST_IDLE;
        end else begin
          tmo_nx = tmo_q + 16'd1;
        end
      end
      ST_FINISH: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, counters and all outputs are registered here
  always_ff @(posedge CLKINB_DEL or posedge RSTB) begin
    if (RSTB) begin
      state_q  <= ST_IDLE;
      tgt_q    <= 5'd0;
      CUR_STEP <= 5'd0;
      settle_q <= 8'd0;
      tmo_q    <= 16'd0;
      DDAMODE  <= 1'b0;
      DDAIZR   <= 1'b0;
      DDAILAG  <= 1'b0;
      DDAIDEL  <= 3'd0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      state_q  <= state_nx;
      tgt_q    <= tgt_nx;
      CUR_STEP <= step_nx;
      settle_q <= settle_nx;
      tmo_q    <= tmo_nx;
      DDAMODE  <= mode_nx;
      DDAIZR   <= izr_nx;
      DDAILAG  <= lag_nx;
      DDAIDEL  <= del_nx;
      BUSY     <= busy_nx;
      DONE     <= done_nx;
      ERR      <= err_nx;
    end
  end

endmodule

// File: tb/tb_pll_dda_stepper.sv
// Directed bench for pll_dda_stepper with SETTLE_CYC=4, LOCK_TIMEOUT=8.
module tb_pll_dda_stepper;

  logic       CLKINB_DEL = 1'b0;
  logic       RSTB = 1'b1;
  logic       REQ = 1'b0;
  logic [4:0] TARGET = 5'd0;
  logic       LOCK = 1'b1;
  logic       DDAMODE, DDAIZR, DDAILAG;
  logic [2:0] DDAIDEL;
  logic [4:0] CUR_STEP;
  logic       BUSY, DONE, ERR;

  int checks = 0;
  int failures = 0;

  // results of the most recent run_move
  int         done_k, err_k, done_cnt, err_cnt, both_cnt;
  logic       busy_k0, busy_at_done, busy_at_err;
  logic [4:0] steps[$];
  logic       izr_h[$];
  logic       lag_h[$];
  logic [2:0] del_h[$];

  pll_dda_stepper #(.SETTLE_CYC(4), .LOCK_TIMEOUT(8)) dut (
    .CLKINB_DEL(CLKINB_DEL), .RSTB(RSTB), .REQ(REQ), .TARGET(TARGET),
    .LOCK(LOCK), .DDAMODE(DDAMODE), .DDAIZR(DDAIZR), .DDAILAG(DDAILAG),
    .DDAIDEL(DDAIDEL), .CUR_STEP(CUR_STEP), .BUSY(BUSY), .DONE(DONE),
    .ERR(ERR)
  );

  always #5 CLKINB_DEL = ~CLKINB_DEL;

  // Issue REQ at a negedge, then record the response edge by edge.
  // k counts rising edges, k=0 being the edge that samples REQ.
  task automatic run_move(input logic [4:0] tgt, input int budget,
                          input int inj_k, input logic [4:0] inj_tgt);
    logic [4:0] prev;
    int end_k;
    steps.delete(); izr_h.delete(); lag_h.delete(); del_h.delete();
    done_k = -1; err_k = -1; done_cnt = 0; err_cnt = 0; both_cnt = 0;
    busy_k0 = 1'b0; busy_at_done = 1'b1; busy_at_err = 1'b1; end_k = -1;
    @(negedge CLKINB_DEL);
    prev = CUR_STEP;
    REQ = 1'b1; TARGET = tgt;
    for (int k = 0; k < budget; k++) begin
      @(posedge CLKINB_DEL); #1;
      REQ = (k == inj_k);
      if (k == inj_k) TARGET = inj_tgt;
      if (k == 0) busy_k0 = BUSY;
      if (CUR_STEP !== prev) begin
        steps.push_back(CUR_STEP); izr_h.push_back(DDAIZR);
        lag_h.push_back(DDAILAG); del_h.push_back(DDAIDEL);
      end
      prev = CUR_STEP;
      if (DONE === 1'b1) begin
        done_cnt++;
        if (done_k < 0) begin done_k = k; busy_at_done = BUSY; end
      end
      if (ERR === 1'b1) begin
        err_cnt++;
        if (err_k < 0) begin err_k = k; busy_at_err = BUSY; end
      end
      if (DONE === 1'b1 && ERR === 1'b1) both_cnt++;
      if (end_k < 0 && (DONE === 1'b1 || ERR === 1'b1)) end_k = k;
      if (end_k >= 0 && k >= end_k + 3) break;
    end
    REQ = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({DDAMODE, DDAIZR, DDAILAG, DDAIDEL, CUR_STEP, BUSY, DONE, ERR} !== 14'd0) begin
      failures++;
      $display("FAIL reset_values: got %b expected 0", {DDAMODE, DDAIZR, DDAILAG, DDAIDEL, CUR_STEP, BUSY, DONE, ERR});
    end
    @(posedge CLKINB_DEL); #2;
    RSTB = 1'b0;
  endtask

  task automatic test_positive_move;
    run_move(5'd2, 40, -1, 5'd0);
    checks++;
    if (busy_k0 !== 1'b1) begin failures++; $display("FAIL pos_busy_set: got %b expected 1", busy_k0); end
    checks++;
    if (done_k !== 13) begin failures++; $display("FAIL pos_done_cycle: got %0d expected 13", done_k); end
    checks++;
    if (done_cnt !== 1 || err_cnt !== 0) begin failures++; $display("FAIL pos_pulses: done=%0d err=%0d expected 1/0", done_cnt, err_cnt); end
    checks++;
    if (busy_at_done !== 1'b0) begin failures++; $display("FAIL pos_busy_clear: got %b expected 0", busy_at_done); end
    checks++;
    if (steps.size() !== 2) begin
      failures++; $display("FAIL pos_step_count: got %0d expected 2", steps.size());
    end else begin
      if ({steps[0], lag_h[0], izr_h[0], del_h[0]} !== {5'd1, 1'b0, 1'b0, 3'd0}) begin
        failures++; $display("FAIL pos_step1: got step=%0d lag=%b izr=%b del=%0d expected 1/0/0/0", steps[0], lag_h[0], izr_h[0], del_h[0]);
      end
      checks++;
      if ({steps[1], lag_h[1], izr_h[1], del_h[1]} !== {5'd2, 1'b0, 1'b0, 3'd1}) begin
        failures++; $display("FAIL pos_step2: got step=%0d lag=%b izr=%b del=%0d expected 2/0/0/1", steps[1], lag_h[1], izr_h[1], del_h[1]);
      end
    end
    checks++;
    if (DDAMODE !== 1'b1) begin failures++; $display("FAIL pos_ddamode: got %b expected 1", DDAMODE); end
  endtask

  task automatic test_neg_through_zero;
    run_move(5'd1, 40, -1, 5'd0);
    checks++;
    if (CUR_STEP !== 5'd1 || done_k !== 7) begin failures++; $display("FAIL neg_prep: step=%0d done_k=%0d expected 1/7", CUR_STEP, done_k); end
    run_move(5'b11111, 40, -1, 5'd0);
    checks++;
    if (done_k !== 13 || done_cnt !== 1 || err_cnt !== 0) begin
      failures++; $display("FAIL neg_done: done_k=%0d done=%0d err=%0d expected 13/1/0", done_k, done_cnt, err_cnt);
    end
    checks++;
    if (steps.size() !== 2) begin
      failures++; $display("FAIL neg_step_count: got %0d expected 2", steps.size());
    end else begin
      if ({steps[0], izr_h[0], lag_h[0], del_h[0]} !== {5'd0, 1'b1, 1'b0, 3'd0}) begin
        failures++; $display("FAIL neg_zero_step: got step=%0d izr=%b lag=%b del=%0d expected 0/1/0/0", steps[0], izr_h[0], lag_h[0], del_h[0]);
      end
      checks++;
      if ({steps[1], izr_h[1], lag_h[1], del_h[1]} !== {5'b11111, 1'b0, 1'b1, 3'd0}) begin
        failures++; $display("FAIL neg_final_step: got step=%0d izr=%b lag=%b del=%0d expected -1/0/1/0", $signed(steps[1]), izr_h[1], lag_h[1], del_h[1]);
      end
    end
  endtask

  task automatic test_same_target;
    run_move(5'b11111, 20, -1, 5'd0);
    checks++;
    if (done_k !== 1 || done_cnt !== 1 || steps.size() !== 0) begin
      failures++; $display("FAIL same_target: done_k=%0d done=%0d steps=%0d expected 1/1/0", done_k, done_cnt, steps.size());
    end
  endtask

  task automatic test_illegal;
    logic [4:0] bad[2];
    bad[0] = 5'd9; bad[1] = 5'b10111;
    for (int i = 0; i < 2; i++) begin
      run_move(bad[i], 10, -1, 5'd0);
      checks++;
      if (err_k !== 0 || err_cnt !== 1 || done_cnt !== 0) begin
        failures++; $display("FAIL illegal_err[%0d]: err_k=%0d err=%0d done=%0d expected 0/1/0", i, err_k, err_cnt, done_cnt);
      end
      checks++;
      if ({BUSY, busy_k0, CUR_STEP, DDAILAG, DDAIZR, DDAIDEL} !== {1'b0, 1'b0, 5'b11111, 1'b1, 1'b0, 3'd0}) begin
        failures++; $display("FAIL illegal_hold[%0d]: busy=%b step=%0d lag=%b izr=%b del=%0d expected 0/-1/1/0/0", i, BUSY, $signed(CUR_STEP), DDAILAG, DDAIZR, DDAIDEL);
      end
    end
  endtask

  task automatic test_back_to_back;
    run_move(5'd1, 40, 3, 5'b11011);
    checks++;
    if (CUR_STEP !== 5'd1 || done_k !== 13 || done_cnt !== 1) begin
      failures++; $display("FAIL busy_req_ignored: step=%0d done_k=%0d done=%0d expected 1/13/1", $signed(CUR_STEP), done_k, done_cnt);
    end
  endtask

  task automatic test_boundary;
    run_move(5'b11000, 150, -1, 5'd0);
    checks++;
    if ({CUR_STEP, DDAILAG, DDAIDEL} !== {5'b11000, 1'b1, 3'd7} || done_k !== 55) begin
      failures++; $display("FAIL bound_neg8: step=%0d lag=%b del=%0d done_k=%0d expected -8/1/7/55", $signed(CUR_STEP), DDAILAG, DDAIDEL, done_k);
    end
    run_move(5'd8, 150, -1, 5'd0);
    checks++;
    if ({CUR_STEP, DDAILAG, DDAIDEL} !== {5'd8, 1'b0, 3'd7} || done_k !== 97 || both_cnt !== 0) begin
      failures++; $display("FAIL bound_pos8: step=%0d lag=%b del=%0d done_k=%0d both=%0d expected 8/0/7/97/0", $signed(CUR_STEP), DDAILAG, DDAIDEL, done_k, both_cnt);
    end
  endtask

  task automatic test_timeout;
    @(negedge CLKINB_DEL);
    RSTB = 1'b1; LOCK = 1'b0;
    repeat (3) @(negedge CLKINB_DEL);
    RSTB = 1'b0;
    run_move(5'd3, 40, -1, 5'd0);
    checks++;
    if (err_k !== 13 || err_cnt !== 1 || done_cnt !== 0) begin
      failures++; $display("FAIL timeout_err: err_k=%0d err=%0d done=%0d expected 13/1/0", err_k, err_cnt, done_cnt);
    end
    checks++;
    if ({CUR_STEP, BUSY, DDAIZR, DDAILAG, DDAIDEL} !== {5'd1, 1'b0, 1'b0, 1'b0, 3'd0} || busy_at_err !== 1'b0) begin
      failures++; $display("FAIL timeout_hold: step=%0d busy=%b izr=%b lag=%b del=%0d expected 1/0/0/0/0", $signed(CUR_STEP), BUSY, DDAIZR, DDAILAG, DDAIDEL);
    end
  endtask

  task automatic test_reset_mid_move;
    int pulses;
    LOCK = 1'b1;
    @(negedge CLKINB_DEL);
    REQ = 1'b1; TARGET = 5'b11101;
    @(posedge CLKINB_DEL); #1;
    REQ = 1'b0;
    @(posedge CLKINB_DEL);
    @(posedge CLKINB_DEL); #3;
    checks++;
    if (BUSY !== 1'b1 || DDAIZR !== 1'b1) begin failures++; $display("FAIL midmove_pre: busy=%b izr=%b expected 1/1", BUSY, DDAIZR); end
    RSTB = 1'b1;
    #1;
    checks++;
    if ({DDAMODE, DDAIZR, DDAILAG, DDAIDEL, CUR_STEP, BUSY, DONE, ERR} !== 14'd0) begin
      failures++; $display("FAIL midmove_reset: got %b expected 0", {DDAMODE, DDAIZR, DDAILAG, DDAIDEL, CUR_STEP, BUSY, DONE, ERR});
    end
    repeat (2) @(posedge CLKINB_DEL);
    #2 RSTB = 1'b0;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge CLKINB_DEL); #1;
      if (DONE !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0) pulses++;
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL midmove_quiet: got %0d active cycles expected 0", pulses); end
    run_move(5'd1, 40, -1, 5'd0);
    checks++;
    if ({CUR_STEP, DDAMODE, DDAIZR, DDAILAG, DDAIDEL} !== {5'd1, 1'b1, 1'b0, 1'b0, 3'd0} || done_k !== 7) begin
      failures++; $display("FAIL midmove_after: step=%0d mode=%b izr=%b done_k=%0d expected 1/1/0/7", $signed(CUR_STEP), DDAMODE, DDAIZR, done_k);
    end
  endtask

  initial begin
    test_reset();
    test_positive_move();
    test_neg_through_zero();
    test_same_target();
    test_illegal();
    test_back_to_back();
    test_boundary();
    test_timeout();
    test_reset_mid_move();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
